// File: rtl/truth_table_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_scanner_pkg
// Description : Shared constants and state encoding for the truth-table scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package truth_table_scanner_pkg;

    localparam int c_N_VARS = 4;
    localparam int c_N_ROWS = 2 ** c_N_VARS;
    localparam int c_IDX_W  = c_N_VARS;
    localparam int c_CNT_W  = $clog2(c_N_ROWS + 1);

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE   = 2'd0;
    localparam state_t c_ST_SETTLE = 2'd1;
    localparam state_t c_ST_SAMPLE = 2'd2;
    localparam state_t c_ST_DONE   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/truth_table_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_scanner_if
// Description : Control, stimulus and result bundle of the truth-table scanner.
// Revision    : 1.0 - initial release
// ============================================================================
interface truth_table_scanner_if;
    import truth_table_scanner_pkg::*;

    logic                 start;
    logic [c_N_ROWS-1:0]  expected;
    logic                 f_in;
    logic [c_IDX_W-1:0]   stim_out;
    logic                 busy;
    logic                 done;
    logic [c_N_ROWS-1:0]  table_out;
    logic                 pass;
    logic [c_CNT_W-1:0]   mismatch_cnt;
    logic [c_IDX_W-1:0]   first_err_idx;
    logic                 err_valid;

    modport master (
        output start, expected, f_in,
        input  stim_out, busy, done, table_out, pass,
               mismatch_cnt, first_err_idx, err_valid
    );

    modport slave (
        input  start, expected, f_in,
        output stim_out, busy, done, table_out, pass,
               mismatch_cnt, first_err_idx, err_valid
    );

endinterface
`default_nettype wire

// File: rtl/truth_table_scanner_timer.sv
`default_nettype none
// ============================================================================
// Module      : scan_settle_timer
// Description : Loadable down-counter; expire is high while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_settle_timer #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_value,
    input  wire logic             enable,
    output logic                  expire
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (enable && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign expire = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/truth_table_scanner.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_scanner
// Description : Walks all input rows of a 4-input function, captures its truth
//               table and compares it against a latched expected mask.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int N_VARS        = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  wire logic               clk,
    input  wire logic               reset,
    truth_table_scanner_if.slave    bus
);

    // Timer counts SETTLE_CYCLES-1 down to 0, giving SETTLE_CYCLES cycles per row.
    localparam int c_TMR_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LOAD = c_TMR_W'(SETTLE_CYCLES - 1);

    state_t                r_state,     w_state_nxt;
    logic [N_VARS-1:0]     r_idx,       w_idx_nxt;
    logic [c_N_ROWS-1:0]   r_expected,  w_expected_nxt;
    logic [c_N_ROWS-1:0]   r_table,     w_table_nxt;
    logic [c_CNT_W-1:0]    r_mismatch,  w_mismatch_nxt;
    logic [N_VARS-1:0]     r_first_err, w_first_err_nxt;
    logic                  r_err_valid, w_err_valid_nxt;
    logic                  w_tmr_load;
    logic                  w_tmr_en;
    logic                  w_tmr_expire;

    scan_settle_timer #(
        .WIDTH (c_TMR_W)
    ) u_settle_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (w_tmr_load),
        .load_value (c_TMR_LOAD),
        .enable     (w_tmr_en),
        .expire     (w_tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_idx       <= '0;
            r_expected  <= '0;
            r_table     <= '0;
            r_mismatch  <= '0;
            r_first_err <= '0;
            r_err_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_expected  <= w_expected_nxt;
            r_table     <= w_table_nxt;
            r_mismatch  <= w_mismatch_nxt;
            r_first_err <= w_first_err_nxt;
            r_err_valid <= w_err_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_expected_nxt  = r_expected;
        w_table_nxt     = r_table;
        w_mismatch_nxt  = r_mismatch;
        w_first_err_nxt = r_first_err;
        w_err_valid_nxt = r_err_valid;
        w_tmr_load      = 1'b0;
        w_tmr_en        = 1'b0;

        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (bus.start) begin
                    w_expected_nxt  = bus.expected;
                    w_table_nxt     = '0;
                    w_mismatch_nxt  = '0;
                    w_first_err_nxt = '0;
                    w_err_valid_nxt = 1'b0;
                    w_idx_nxt       = '0;
                    w_tmr_load      = 1'b1;
                    w_state_nxt     = c_ST_SETTLE;
                end
            end
            c_ST_SETTLE: begin
                w_tmr_en = 1'b1;
                if (w_tmr_expire) begin
                    w_state_nxt = c_ST_SAMPLE;
                end
            end
            c_ST_SAMPLE: begin
                w_table_nxt[r_idx] = bus.f_in;
                if (bus.f_in != r_expected[r_idx]) begin
                    w_mismatch_nxt = r_mismatch + c_CNT_W'(1);
                    if (!r_err_valid) begin
                        w_first_err_nxt = r_idx;
                        w_err_valid_nxt = 1'b1;
                    end
                end
                if (r_idx == N_VARS'(c_N_ROWS - 1)) begin
                    w_state_nxt = c_ST_DONE;
                end else begin
                    w_idx_nxt   = r_idx + N_VARS'(1);
                    w_tmr_load  = 1'b1;
                    w_state_nxt = c_ST_SETTLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign bus.busy          = (r_state == c_ST_SETTLE) || (r_state == c_ST_SAMPLE);
    assign bus.done          = (r_state == c_ST_DONE);
    assign bus.stim_out      = (r_state == c_ST_IDLE) ? '0 : r_idx;
    assign bus.table_out     = r_table;
    assign bus.mismatch_cnt  = r_mismatch;
    assign bus.first_err_idx = r_first_err;
    assign bus.err_valid     = r_err_valid;
    assign bus.pass          = (r_state == c_ST_DONE) && (r_mismatch == '0);

endmodule
`default_nettype wire

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential stimulus-and-capture engine for 4-input combinational functions such as the team's SoP/PoS gate-level blocks.
- Walks the input index M from 0 to 15 and drives it to the function under test.
- After a settle interval it samples the function's output into a 16-bit truth-table register.
- Compares the result against an expected minterm mask and reports pass/fail, the mismatch count and the first failing row.

Parameters:
- N_VARS, 4: number of function inputs; rows = 2**N_VARS. Only 4 is required to be supported.
- SETTLE_CYCLES, 1: clock cycles each row is driven before it is sampled. Must be ≥1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a scan; accepted only in IDLE or DONE.
- expected  input  16  expected output mask; bit i = function value at row i. Latched on start accept.
- f_in  input  1  output of the function under test.
- stim_out  output  4  current row index; stim_out[3]=X (MSB), [2]=Y, [1]=W, [0]=Z.
- busy  output  1  high in SETTLE and SAMPLE.
- done  output  1  high in DONE; held until next start accept or reset.
- table_out  output  16  captured truth table; bit i = f_in sampled at row i.
- pass  output  1  done && (mismatch_cnt == 0).
- mismatch_cnt  output  5  number of rows where captured ≠ expected; range 0..16.
- first_err_idx  output  4  lowest failing row index; valid only when err_valid=1.
- err_valid  output  1  at least one mismatch recorded in the current scan.

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - State goes to IDLE.
  - stim_out, table_out, mismatch_cnt, first_err_idx, expected latch and settle counter go to 0.
  - busy, done, pass and err_valid go to 0.
  - Reset has priority over start and over any state, including mid-scan.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - stim_out=0.
  - On start=1: latch expected, clear table_out, mismatch_cnt, err_valid and first_err_idx, set idx=0 and settle count=0, go to SETTLE.
- SETTLE:
  - stim_out=idx.
  - The counter increments each cycle.
  - When count reaches SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE:
  - stim_out=idx. At this edge, table_out[idx] <= f_in.
  - If f_in ≠ expected_latched[idx]: mismatch_cnt increments by 1. If err_valid=0, also set first_err_idx=idx and err_valid=1.
  - If idx==15, go to DONE. Otherwise idx <= idx+1, clear the counter and go to SETTLE.
  - idx never wraps within a scan.
- DONE:
  - stim_out holds 15, done=1 and results are held.
  - start=1 restarts exactly as from IDLE; done falls on the accept edge.
- Latency:
  - Each row takes SETTLE_CYCLES+1 cycles.
  - done rises 16*(SETTLE_CYCLES+1) edges after the start-accept edge: 32 with the default parameter.
- Ignored inputs:
  - start while busy is ignored.
  - Changes on expected while busy are ignored (the latched copy is used).
- Comparison uses the latched expected value only.
- mismatch_cnt saturates naturally at 16; no overflow is possible with 5 bits.
- f_in is sampled only in SAMPLE and ignored in every other state.

Decomposition:
- Shared package (scanner_pkg):
  - State enum {IDLE, SETTLE, SAMPLE, DONE}.
  - Constants N_ROWS = 2**N_VARS and IDX_W = N_VARS.
  - CNT_W = $clog2(N_ROWS+1), which is 5.
- One sub-module, scan_settle_timer:
  - Parameterised down-counter with load, enable and expire outputs.
  - Instantiated once to time SETTLE.
- Compare/capture logic and the FSM stay in the top module.

Test Plan:
1. Reference PoS function model on f_in, expected=16'h1894, pulse start → done after 32 cycles, table_out=16'h1894, pass=1, mismatch_cnt=0, err_valid=0.
2. f_in stuck at 0, expected=16'h1894 → table_out=16'h0000, mismatch_cnt=5, first_err_idx=2, err_valid=1, pass=0.
3. Correct model, assert reset at cycle 10 of a scan → next edge: IDLE, stim_out=0, busy=0, done=0, table_out=0. Then start again → normal pass with table_out=16'h1894.
4. Hold start=1 through a whole scan, and change expected to 16'hFFFF at cycle 5 → second start ignored while busy, results computed against 16'h1894 (pass=1). Scan restarts on the cycle after DONE because start is still high.
5. SETTLE_CYCLES=3, inverted model (16'hE76B), expected=16'h1894 → done after 64 cycles, mismatch_cnt=16, first_err_idx=0, stim_out held at each row for 4 cycles.
6. Restart from DONE with start pulse → done drops on the accept edge; previous table_out and error fields are cleared before the first SAMPLE.
